// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes, FSM
// state encoding, iteration count and a magnitude helper.
package mdu_pkg;

  localparam int ITER_N = 32;
  localparam int ITER_W = $clog2(ITER_N);

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } mdu_state_e;

  function automatic logic [31:0] abs32(input logic [31:0] v, input logic signed_op);
    return (signed_op && v[31]) ? -v : v;
  endfunction

endpackage

// File: rtl/mdu_if.sv
// Issue/result bundle between the EX stage and the multiply/divide unit.
interface mdu_if;
  import mdu_pkg::*;

  // start is a one-cycle issue strobe with no ready: it is honoured only in
  // IDLE without flush, and the stall unit holds off issue while isbusy=1.
  logic        start;
  mdu_op_e     op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        isbusy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  mdu_state_e  state;

  modport master (
    output start, op, src_a, src_b, flush,
    input  isbusy, done, hi, lo, state
  );

  modport slave (
    input  start, op, src_a, src_b, flush,
    output isbusy, done, hi, lo, state
  );

endinterface

// File: rtl/md_iter.sv
// One iteration of shift-add multiply or restoring shift-subtract divide on a
// 64-bit accumulator; the accumulator itself lives here.
module md_iter
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        step,
  input  logic        is_div,
  input  logic [63:0] load_val,
  input  logic [31:0] operand,
  output logic [63:0] acc
);

  logic [63:0] acc_q, acc_d;
  logic [32:0] mul_sum;
  logic [32:0] rem_sh;
  logic [33:0] diff;
  logic [63:0] step_val;

  always_comb begin
    mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, operand} : 33'd0);
    // The shifted partial remainder needs 33 bits before the trial subtract.
    rem_sh  = acc_q[63:31];
    diff    = {1'b0, rem_sh} - {2'b00, operand};
    if (is_div) begin
      step_val = diff[33] ? {rem_sh[31:0], acc_q[30:0], 1'b0}
                          : {diff[31:0],   acc_q[30:0], 1'b1};
    end else begin
      step_val = {mul_sum, acc_q[31:1]};
    end

    acc_d = acc_q;
    if (load)      acc_d = load_val;
    else if (step) acc_d = step_val;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide controller: issue FSM, iteration counter, sign correction
// and the architectural HI/LO registers.
module mdu_ctrl
  import mdu_pkg::*;
(
  input logic  clk,
  input logic  rst_n,
  mdu_if.slave bus
);

  mdu_state_e        state_q, state_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic [31:0]       opnd_q, opnd_d;
  logic [31:0]       a_raw_q, a_raw_d;
  logic              neg_q, neg_d;
  logic              neg_r_q, neg_r_d;
  logic              div_q, div_d;
  logic              dvz_q, dvz_d;
  logic              isbusy_q, isbusy_d;
  logic [31:0]       hi_q, hi_d;
  logic [31:0]       lo_q, lo_d;

  logic        done;
  logic        acc_load, acc_step;
  logic [63:0] acc_load_val;
  logic [63:0] acc;
  logic        sgn, is_md, is_dv;
  logic [31:0] a_abs, b_abs;
  logic [63:0] prod;
  logic [31:0] quo, rem;

  md_iter u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (acc_load),
    .step     (acc_step),
    .is_div   (div_q),
    .load_val (acc_load_val),
    .operand  (opnd_q),
    .acc      (acc)
  );

  always_comb begin
    state_d      = state_q;
    iter_d       = iter_q;
    opnd_d       = opnd_q;
    a_raw_d      = a_raw_q;
    neg_d        = neg_q;
    neg_r_d      = neg_r_q;
    div_d        = div_q;
    dvz_d        = dvz_q;
    isbusy_d     = isbusy_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    done         = 1'b0;
    acc_load     = 1'b0;
    acc_step     = 1'b0;
    acc_load_val = '0;

    sgn   = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    is_dv = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
    is_md = is_dv || (bus.op == OP_MULT) || (bus.op == OP_MULTU);
    a_abs = abs32(bus.src_a, sgn);
    b_abs = abs32(bus.src_b, sgn);

    prod = neg_q   ? -acc         : acc;
    quo  = neg_q   ? -acc[31:0]   : acc[31:0];
    rem  = neg_r_q ? -acc[63:32]  : acc[63:32];

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.flush) begin
          if (is_md) begin
            state_d      = ST_CALC;
            iter_d       = '0;
            isbusy_d     = 1'b1;
            div_d        = is_dv;
            neg_d        = sgn && (bus.src_a[31] ^ bus.src_b[31]);
            neg_r_d      = sgn && bus.src_a[31];
            dvz_d        = is_dv && (bus.src_b == 32'd0);
            a_raw_d      = bus.src_a;
            opnd_d       = is_dv ? b_abs : a_abs;
            acc_load     = 1'b1;
            acc_load_val = is_dv ? {32'd0, a_abs} : {32'd0, b_abs};
          end else if (bus.op == OP_MTHI) begin
            hi_d = bus.src_a;
          end else if (bus.op == OP_MTLO) begin
            lo_d = bus.src_a;
          end
        end
      end
      ST_CALC: begin
        acc_step = 1'b1;
        if (iter_q == ITER_W'(ITER_N - 1)) state_d = ST_FIX;
        else                               iter_d  = iter_q + 1'b1;
      end
      ST_FIX: begin
        done     = 1'b1;
        state_d  = ST_IDLE;
        isbusy_d = 1'b0;
        iter_d   = '0;
        if (!div_q) begin
          hi_d = prod[63:32];
          lo_d = prod[31:0];
        end else if (dvz_q) begin
          hi_d = a_raw_q;
          lo_d = 32'hFFFF_FFFF;
        end else begin
          hi_d = rem;
          lo_d = quo;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Flush kills everything in flight, including the HI/LO write in FIX.
    if (bus.flush) begin
      state_d  = ST_IDLE;
      isbusy_d = 1'b0;
      iter_d   = '0;
      done     = 1'b0;
      hi_d     = hi_q;
      lo_d     = lo_q;
      acc_load = 1'b0;
      acc_step = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      iter_q   <= '0;
      opnd_q   <= '0;
      a_raw_q  <= '0;
      neg_q    <= 1'b0;
      neg_r_q  <= 1'b0;
      div_q    <= 1'b0;
      dvz_q    <= 1'b0;
      isbusy_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      iter_q   <= iter_d;
      opnd_q   <= opnd_d;
      a_raw_q  <= a_raw_d;
      neg_q    <= neg_d;
      neg_r_q  <= neg_r_d;
      div_q    <= div_d;
      dvz_q    <= dvz_d;
      isbusy_q <= isbusy_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign bus.isbusy = isbusy_q;
  assign bus.done   = done;
  assign bus.hi     = hi_q;
  assign bus.lo     = lo_q;
  assign bus.state  = state_q;

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 clk  in  1  sole clock; all state updates on the rising edge.
REQ-002 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-003 start  in  1  EX-stage multiply/divide issue strobe, qualified by ID_EXWr.
REQ-004 op  in  3  operation: MULT, MULTU, DIV, DIVU, MTHI, MTLO (codes in shared package).
REQ-005 src_a  in  32  rs value: multiplicand, dividend, or MTHI/MTLO data.
REQ-006 src_b  in  32  rt value: multiplier or divisor.
REQ-007 flush  in  1  MEM1_ex | MEM1_eret_flush; kills any in-flight operation.
REQ-008 isbusy  out  1  registered; operation in progress, feeds the stall unit.
REQ-009 done  out  1  one-cycle pulse in the cycle HI/LO are written by MULT/DIV.
REQ-010 hi  out  32  architectural HI register.
REQ-011 lo  out  32  architectural LO register.

Function
REQ-012 States SHALL be IDLE, CALC and FIX; the encoding SHALL live in the shared package.
REQ-013 IDLE accept: start=1, flush=0 and op in {MULT, MULTU, DIV, DIVU} SHALL latch the operands, load iter=0 and enter CALC; isbusy=1 from the next cycle.
REQ-014 Signed ops SHALL latch absolute values plus sign flags; unsigned ops SHALL latch raw values.
REQ-015 CALC SHALL perform one shift-add (multiply) or one restoring shift-subtract (divide) step per cycle for exactly 32 cycles (iter 0..31), then enter FIX.
REQ-016 FIX (1 cycle) SHALL apply sign correction and write hi/lo at cycle end, pulse done, and return to IDLE.
REQ-017 Sign rules: product negated if the operand signs differ; quotient negated if the signs differ; remainder takes the dividend sign.
REQ-018 Multiply results: hi = product[63:32], lo = product[31:0], 64-bit two's complement.
REQ-019 Divide results: lo = quotient, hi = remainder.
REQ-020 Divisor=0: hi=src_a and lo=32'hFFFFFFFF regardless of signedness, with no sign correction; latency unchanged.
REQ-021 Latency: start sampled in cycle t; hi/lo are valid from cycle t+34; isbusy is high in cycles t+1..t+33.
REQ-022 MTHI/MTLO in IDLE with start=1, flush=0 SHALL write hi or lo at cycle end, with no busy and no done.
REQ-023 start while not IDLE SHALL be ignored; the stall unit guarantees it does not occur.
REQ-024 flush in any state SHALL force IDLE next cycle: isbusy=0, done=0, hi/lo unchanged, including a flush in the FIX cycle.
REQ-025 flush and start in the same cycle: flush wins; nothing is latched.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE, isbusy=0, done=0, hi=0, lo=0, iter=0, and clear the operand registers.
REQ-027 Reset mid-CALC SHALL abandon the operation; the first start after release SHALL behave as from power-up.

Structure
REQ-028 Package mdu_pkg SHALL hold the op codes, state encoding and ITER_N=32.
REQ-029 The per-cycle iteration datapath (64-bit accumulator, shift, add/subtract select) SHALL be a sub-module md_iter; mdu_ctrl holds the FSM, counter, sign fix and HI/LO.

Verification
REQ-030 MULT -3 x 5 -> after 34 cycles hi=FFFFFFFF, lo=FFFFFFF1, done pulses once, isbusy high 33 cycles.
REQ-031 DIV -7 / 2 -> lo=FFFFFFFD, hi=FFFFFFFF; DIVU 7 / 0 -> hi=00000007, lo=FFFFFFFF.
REQ-032 MULTU FFFFFFFF x FFFFFFFF -> hi=FFFFFFFE, lo=00000001.
REQ-033 DIV issued, flush at CALC iter 10 -> isbusy=0 next cycle, hi/lo keep prior values, no done.
REQ-034 MTHI 12345678 when idle -> hi=12345678 next cycle, isbusy stays 0; MTLO with flush=1 -> lo unchanged.
REQ-035 rst_n low mid-CALC -> outputs zero asynchronously; MULT 2 x 3 after release -> lo=6, hi=0.
